// File: rtl/fifo_pkg.sv
// fifo_pkg: shared occupancy-width helper and status flag bit positions for the queue family
package fifo_pkg;

    // Bit positions inside the packed status word
    // {overflow, underflow, almost_full, almost_empty, full, empty}
    typedef enum logic [2:0] {
        FLAG_EMPTY = 3'd0,
        FLAG_FULL  = 3'd1,
        FLAG_AE    = 3'd2,
        FLAG_AF    = 3'd3,
        FLAG_UNF   = 3'd4,
        FLAG_OVF   = 3'd5
    } fifo_flag_e;

    localparam int FLAG_W = 6;

    // Occupancy counter width: must hold every value 0..size inclusive
    function automatic int fifo_lw(input int size);
        return $clog2(size + 1);
    endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// fifo_wrap_ptr: modulo-SIZE pointer that wraps explicitly, so non-power-of-2 depths work
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter  int SIZE = 4,
    localparam int PW   = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] LAST = PW'(SIZE - 1);

    logic [PW-1:0] r_ptr;

    // Advance on each accept, returning to 0 after the last slot; flush wins over inc
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_ptr <= '0;
        else if (clr)
            r_ptr <= '0;
        else if (inc)
            r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/fifo_level.sv
// fifo_level: parametrised show-ahead FIFO with occupancy, thresholds, flush and sticky error flags
// Optional high-water mark output peak_level is built when FIFO_LEVEL_PEAK_EN is defined.
module fifo_level
    import fifo_pkg::*;
#(
    parameter  int SIZE      = 4,
    parameter  int WIDTH     = 8,
    parameter  int AF_THRESH = SIZE - 1,
    parameter  int AE_THRESH = 1,
    localparam int LW        = fifo_lw(SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             write_en,
    input  logic [WIDTH-1:0] write_data,
    input  logic             read_en,
    output logic [WIDTH-1:0] read_data,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic [LW-1:0]    level,
    output logic             overflow,
    output logic             underflow
`ifdef FIFO_LEVEL_PEAK_EN
    ,
    output logic [LW-1:0]    peak_level
`endif
);

    localparam int            PW     = $clog2(SIZE);
    localparam logic [LW-1:0] L_SIZE = LW'(SIZE);
    localparam logic [LW-1:0] L_AF   = LW'(AF_THRESH);
    localparam logic [LW-1:0] L_AE   = LW'(AE_THRESH);

    logic [WIDTH-1:0]  r_mem [SIZE];
    logic [LW-1:0]     r_level;
    logic              r_ovf;
    logic              r_unf;
    logic [PW-1:0]     w_rptr;
    logic [PW-1:0]     w_wptr;
    logic [LW-1:0]     w_level_nxt;
    logic              w_do_rd;
    logic              w_do_wr;
    logic [FLAG_W-1:0] w_status;

    // Status word decoded purely from registered state
    always_comb begin
        w_status               = '0;
        w_status[FLAG_EMPTY]   = (r_level == '0);
        w_status[FLAG_FULL]    = (r_level == L_SIZE);
        w_status[FLAG_AE]      = (r_level <= L_AE);
        w_status[FLAG_AF]      = (r_level >= L_AF);
        w_status[FLAG_UNF]     = r_unf;
        w_status[FLAG_OVF]     = r_ovf;
    end

    assign empty        = w_status[FLAG_EMPTY];
    assign full         = w_status[FLAG_FULL];
    assign almost_empty = w_status[FLAG_AE];
    assign almost_full  = w_status[FLAG_AF];
    assign underflow    = w_status[FLAG_UNF];
    assign overflow     = w_status[FLAG_OVF];
    assign level        = r_level;

    // A read frees a slot in the same edge, so a full FIFO may still take a write alongside it
    assign w_do_rd = read_en && !empty && !clr;
    assign w_do_wr = write_en && (!full || read_en) && !clr;

    // Next occupancy: flush empties, a lone accept moves by one, paired accepts cancel
    always_comb begin
        w_level_nxt = clr                   ? '0 :
                      (w_do_wr && !w_do_rd) ? r_level + 1'b1 :
                      (w_do_rd && !w_do_wr) ? r_level - 1'b1 :
                                              r_level;
    end

    fifo_wrap_ptr #(.SIZE(SIZE)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (w_do_rd),
        .ptr (w_rptr)
    );

    fifo_wrap_ptr #(.SIZE(SIZE)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (w_do_wr),
        .ptr (w_wptr)
    );

    // Occupancy and sticky error flags; errors hold until reset or flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            r_ovf   <= !clr && (r_ovf || (write_en && full && !read_en));
            r_unf   <= !clr && (r_unf || (read_en && empty));
        end
    end

    // Storage is deliberately not reset; only accepted writes land
    always_ff @(posedge clk) begin
        if (w_do_wr)
            r_mem[w_wptr] <= write_data;
    end

    assign read_data = r_mem[w_rptr];

`ifdef FIFO_LEVEL_PEAK_EN
    logic [LW-1:0] r_peak;

    // High-water mark tracks the level being written at the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_peak <= '0;
        else if (clr)
            r_peak <= '0;
        else if (w_level_nxt > r_peak)
            r_peak <= w_level_nxt;
    end

    assign peak_level = r_peak;
`endif

endmodule

// File: tb/tb_fifo_level.sv
// tb_fifo_level: two configurations (SIZE=5 defaults, SIZE=8 AF=6 AE=2) driven in lockstep against queue models
module tb_fifo_level;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic       write_en;
    logic [7:0] write_data;
    logic       read_en;

    logic [7:0] rd_a, rd_b;
    logic       empty_a, full_a, ae_a, af_a, ovf_a, unf_a;
    logic       empty_b, full_b, ae_b, af_b, ovf_b, unf_b;
    logic [2:0] level_a, peak_a;
    logic [3:0] level_b, peak_b;

    int checks = 0;
    int errors = 0;

    typedef logic [7:0] q_t[$];
    q_t mq[2];
    bit mov[2];
    bit mun[2];
    int mpk[2];
    int SZ[2]  = '{5, 8};
    int AFT[2] = '{4, 6};
    int AET[2] = '{1, 2};

    always #5 clk = ~clk;

    fifo_level #(.SIZE(5), .WIDTH(8)) u_a (
        .clk(clk), .rst(rst), .clr(clr), .write_en(write_en), .write_data(write_data),
        .read_en(read_en), .read_data(rd_a), .empty(empty_a), .full(full_a),
        .almost_empty(ae_a), .almost_full(af_a), .level(level_a),
        .overflow(ovf_a), .underflow(unf_a)
`ifdef FIFO_LEVEL_PEAK_EN
        , .peak_level(peak_a)
`endif
    );

    fifo_level #(.SIZE(8), .WIDTH(8), .AF_THRESH(6), .AE_THRESH(2)) u_b (
        .clk(clk), .rst(rst), .clr(clr), .write_en(write_en), .write_data(write_data),
        .read_en(read_en), .read_data(rd_b), .empty(empty_b), .full(full_b),
        .almost_empty(ae_b), .almost_full(af_b), .level(level_b),
        .overflow(ovf_b), .underflow(unf_b)
`ifdef FIFO_LEVEL_PEAK_EN
        , .peak_level(peak_b)
`endif
    );

`ifndef FIFO_LEVEL_PEAK_EN
    assign peak_a = '0;
    assign peak_b = '0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            mov[k] = 0;
            mun[k] = 0;
            mpk[k] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int n;
            bit f, e, rd, wr;
            n  = mq[k].size();
            f  = (n == SZ[k]);
            e  = (n == 0);
            rd = read_en && !e;
            wr = write_en && (!f || read_en);
            if (clr) begin
                mq[k].delete();
                mov[k] = 0;
                mun[k] = 0;
                mpk[k] = 0;
            end else begin
                if (write_en && f && !read_en) mov[k] = 1;
                if (read_en && e) mun[k] = 1;
                if (rd) void'(mq[k].pop_front());
                if (wr) mq[k].push_back(write_data);
                if (mq[k].size() > mpk[k]) mpk[k] = mq[k].size();
            end
        end
    endtask

    task automatic check_dut(input int k, input string nm, input logic [31:0] lvl,
                             input logic e, input logic f, input logic ae, input logic af,
                             input logic ov, input logic un, input logic [7:0] rd,
                             input logic [31:0] pk);
        int n;
        n = mq[k].size();
        chk({nm, "_level"}, lvl, n);
        chk({nm, "_empty"}, e, n == 0);
        chk({nm, "_full"}, f, n == SZ[k]);
        chk({nm, "_almost_empty"}, ae, n <= AET[k]);
        chk({nm, "_almost_full"}, af, n >= AFT[k]);
        chk({nm, "_overflow"}, ov, mov[k]);
        chk({nm, "_underflow"}, un, mun[k]);
        if (n > 0) chk({nm, "_read_data"}, rd, mq[k][0]);
`ifdef FIFO_LEVEL_PEAK_EN
        chk({nm, "_peak_level"}, pk, mpk[k]);
`endif
    endtask

    task automatic check_all();
        check_dut(0, "a", level_a, empty_a, full_a, ae_a, af_a, ovf_a, unf_a, rd_a, peak_a);
        check_dut(1, "b", level_b, empty_b, full_b, ae_b, af_b, ovf_b, unf_b, rd_b, peak_b);
    endtask

    task automatic cyc(input bit c, input bit we, input logic [7:0] wd, input bit re);
        clr        = c;
        write_en   = we;
        write_data = wd;
        read_en    = re;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; write_en = 1'b0; write_data = '0; read_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        cyc(0, 1, 8'h11, 0);
        cyc(0, 1, 8'h22, 0);
        cyc(0, 1, 8'h33, 0);
        chk("a_level_after_3", level_a, 3);
        chk("b_ae_off_at_3", ae_b, 0);
        chk("a_head_first", rd_a, 8'h11);
        repeat (3) cyc(0, 0, 8'h00, 1);
        chk("a_empty_after_drain", empty_a, 1);

        for (int i = 1; i <= 5; i++) cyc(0, 1, 8'(i), 0);
        chk("a_full_after_5", full_a, 1);
        chk("a_level_5", level_a, 5);
        cyc(0, 1, 8'hAA, 1);
        chk("a_full_rw_level", level_a, 5);
        chk("a_full_rw_ovf", ovf_a, 0);
        chk("a_full_rw_head", rd_a, 8'h02);
        cyc(0, 1, 8'h06, 0);
        chk("a_ovf_set", ovf_a, 1);
        repeat (8) cyc(0, 0, 8'h00, 1);
        chk("a_unf_set", unf_a, 1);
        cyc(1, 0, 8'h00, 0);

        cyc(0, 1, 8'hAA, 1);
        chk("a_empty_rw_level", level_a, 1);
        chk("a_empty_rw_unf", unf_a, 1);
        chk("a_empty_rw_data", rd_a, 8'hAA);
        cyc(1, 0, 8'h00, 0);

        for (int i = 0; i < 6; i++) cyc(0, 1, 8'(8'h40 + i), 0);
        repeat (2) cyc(0, 0, 8'h00, 1);
        chk("a_pre_flush_level", level_a, 3);
        chk("a_pre_flush_ovf", ovf_a, 1);
        cyc(1, 1, 8'hEE, 0);
        chk("a_flush_level", level_a, 0);
        chk("a_flush_empty", empty_a, 1);
        chk("a_flush_ovf", ovf_a, 0);
        cyc(0, 1, 8'h5A, 0);
        chk("a_flush_write_dropped", rd_a, 8'h5A);
        cyc(1, 0, 8'h00, 0);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5; i++) cyc(0, 1, 8'(16 * r + i + 1), 0);
            repeat (5) cyc(0, 0, 8'h00, 1);
        end
        cyc(1, 0, 8'h00, 0);

        for (int i = 0; i < 8; i++) cyc(0, 1, 8'(8'hC0 + i), 0);
        chk("b_af_at_8", af_b, 1);
        repeat (8) cyc(0, 0, 8'h00, 1);
        cyc(1, 0, 8'h00, 0);

        for (int i = 0; i < 4; i++) cyc(0, 1, 8'(8'h70 + i), 0);
        chk("a_level_4_before_rst", level_a, 4);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("a_async_rst_level", level_a, 0);
        chk("b_async_rst_empty", empty_b, 1);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc(0, 1, 8'(8'h90 + i), 0);
`ifdef FIFO_LEVEL_PEAK_EN
        chk("a_peak_after_refill", peak_a, 4);
`endif

        for (int i = 0; i < 800; i++) begin
            int p;
            p = ((i / 100) % 2) ? 30 : 70;
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 99) < p,
                8'($urandom), $urandom_range(0, 99) < (100 - p));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_level.md
Name: fifo_level

Overview:
- Parametrised synchronous FIFO, successor to the basic 4-entry buffer. Used for command, write-data and read-return queues between the DRAM controller front end and the sequencer.
- Adds:
  - arbitrary depth, including non-power-of-2;
  - an occupancy count;
  - programmable almost-full and almost-empty thresholds;
  - a synchronous flush;
  - sticky overflow and underflow error flags;
  - correct handling of simultaneous read and write at the full and empty boundaries.

Parameters:
- SIZE, 4: number of entries; legal range 2 or more, any integer.
- WIDTH, 8: data width in bits.
- AF_THRESH, SIZE-1: almost_full asserts when level >= AF_THRESH; legal range 1..SIZE.
- AE_THRESH, 1: almost_empty asserts when level <= AE_THRESH; legal range 0..SIZE-1.
- LW: localparam, $clog2(SIZE+1); width of level.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush.
- write_en  in  1  push request.
- write_data  in  WIDTH  push data.
- read_en  in  1  pop request.
- read_data  out  WIDTH  head-of-queue data (show-ahead).
- empty  out  1  level == 0.
- full  out  1  level == SIZE.
- almost_empty  out  1  level <= AE_THRESH.
- almost_full  out  1  level >= AF_THRESH.
- level  out  LW  current occupancy.
- overflow  out  1  sticky flag: a write was dropped.
- underflow  out  1  sticky flag: a read of an empty FIFO occurred.

Behaviour:
- Clocking and reset:
  - Single clock domain on clk.
  - rst is asynchronous and active-high.
- Reset values:
  - read pointer = 0, write pointer = 0, level = 0.
  - empty = 1, full = 0, almost_empty = 1.
  - almost_full = 0, provided AF_THRESH > 0.
  - overflow = 0, underflow = 0.
  - Storage is not reset; read_data is undefined while empty.
- All flags are decoded from the registered level, so they are valid in the cycle after the edge that changed it.
- Accept rules, evaluated per cycle:
  - do_rd = read_en && !empty.
  - do_wr = write_en && (!full || read_en).
  - When full and both requests are present, the read and the write are both accepted; level is unchanged.
  - When empty and both requests are present, only the write is accepted; level goes up by 1 and underflow is set.
- Level update:
  - do_wr && !do_rd: level + 1.
  - do_rd && !do_wr: level - 1.
  - Otherwise: level unchanged.
  - Level never leaves the range 0..SIZE.
- Pointers:
  - Each pointer is $clog2(SIZE) bits wide.
  - Each increments on its own accept and wraps from SIZE-1 to 0; a plain binary roll-over is not relied on.
- Latency:
  - Written data appears on read_data one cycle after the write edge, when the FIFO was empty.
  - read_data = storage[read pointer], combinational from registers.
  - A pop advances read_data at the same edge.
- Error flags:
  - overflow sets on write_en && full && !read_en; the data is dropped.
  - underflow sets on read_en && empty.
  - Both flags hold until rst or clr.
- Flush (clr = 1):
  - At the next edge, pointers, level, overflow and underflow all clear.
  - clr has priority over any write_en or read_en in the same cycle; neither is accepted.
- Reset asserted mid-operation: immediate return to the reset values, contents discarded.

Optional Feature:
- Macro: FIFO_LEVEL_PEAK_EN.
- With the macro defined:
  - Adds output peak_level (width LW): the high-water mark of level.
  - peak_level updates at the same edge as level whenever the next level exceeds it.
  - Cleared by rst or clr.
  - Used for queue sizing during bring-up.
- Without the macro: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package fifo_pkg holds:
  - the function that computes the occupancy width (LW), shared with the other queues;
  - an enum or constants for the flag bit positions, used by the status register that packs {overflow, underflow, almost_full, almost_empty, full, empty}.
- One sub-module, fifo_wrap_ptr:
  - parameter SIZE;
  - inputs clk, rst, clr, inc;
  - output ptr, with modulo-SIZE wrap.
  - Instantiated twice, once for the read pointer and once for the write pointer.

Test Plan:
- Basic order: SIZE=4, WIDTH=8; write 0x11, 0x22, 0x33, then read 3 times.
  - read_data shows 0x11, 0x22, 0x33 in order.
  - level goes 1, 2, 3, 2, 1, 0; empty reasserts after the last pop.
- Full, overflow and wrap: SIZE=5 (non-power-of-2); write 6 times with no reads.
  - full=1 and level=5 after the 5th write.
  - The 6th write is dropped and sets overflow=1.
  - 5 reads return the first 5 values; the pointers wrap correctly over 3 further fill/drain cycles.
- Simultaneous read and write at the boundaries:
  - When full, read_en=write_en=1 with 0xAA: level stays at SIZE, head advances, 0xAA lands at the tail, overflow stays 0.
  - When empty, the same request: level goes to 1, underflow=1, read_data=0xAA next cycle.
- Thresholds: SIZE=8, AF_THRESH=6, AE_THRESH=2; fill one entry at a time.
  - almost_empty deasserts at level 3.
  - almost_full asserts at level 6 and deasserts when level drops back to 5.
- Flush priority: level=3 with overflow set; pulse clr together with write_en=1.
  - Next cycle: level=0, empty=1, overflow=0; the write is not stored.
- Async reset mid-transfer: assert rst between clock edges while level=4.
  - All outputs take their reset values immediately, before the next edge.
  - With FIFO_LEVEL_PEAK_EN defined, peak_level=0 after reset, and reads 4 after refilling to 4.
